// File: rtl/counter_pkg.sv
// Shared constants and helpers for the loadable up/down counter.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Bit width needed to count 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Enable-gated prescaler; tick marks the cycle on which the counter steps.
module prescaler_tick
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = ena && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_load_counter.sv
// Loadable up/down counter with prescaler, wrap/saturate bounds,
// terminal-count pulse, compare match and sticky overflow.
module updown_load_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic [WIDTH-1:0] cmp_value,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic             SAT = (SATURATE == MODE_SAT);

    logic             tick;
    logic             hit;
    logic [WIDTH-1:0] count_next;

    prescaler_tick #(
        .PRESCALE(PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .ena  (ena),
        .clr  (load),
        .tick (tick)
    );

    // Load overrides any step landing on the same edge.
    always_comb begin
        count_next = count;
        hit        = 1'b0;
        if (load) begin
            count_next = load_value;
        end else if (tick) begin
            if (up == DIR_UP) begin
                if (count == MAX) begin
                    hit        = 1'b1;
                    count_next = SAT ? MAX : '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    hit        = 1'b1;
                    count_next = SAT ? '0 : MAX;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            match <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= hit;
            match <= (count_next == cmp_value);
            if (hit)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_load_counter.sv
// Directed bench: wrap, saturate and prescaled counter instances.
module tb_updown_load_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       load;
    logic [7:0] load_value;
    logic       up;
    logic [7:0] cmp_value;
    logic       clr_ovf;

    logic [7:0] count_w, count_s, count_p;
    logic       tc_w, tc_s, tc_p;
    logic       match_w, match_s, match_p;
    logic       ovf_w, ovf_s, ovf_p;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_load_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load),
        .load_value(load_value), .up(up), .cmp_value(cmp_value),
        .clr_ovf(clr_ovf), .count(count_w), .tc(tc_w),
        .match(match_w), .ovf(ovf_w)
    );

    updown_load_counter #(.WIDTH(8), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load),
        .load_value(load_value), .up(up), .cmp_value(cmp_value),
        .clr_ovf(clr_ovf), .count(count_s), .tc(tc_s),
        .match(match_s), .ovf(ovf_s)
    );

    updown_load_counter #(.WIDTH(8), .PRESCALE(4), .SATURATE(0)) u_pre (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load),
        .load_value(load_value), .up(up), .cmp_value(cmp_value),
        .clr_ovf(clr_ovf), .count(count_p), .tc(tc_p),
        .match(match_p), .ovf(ovf_p)
    );

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; load = 1'b0; load_value = '0;
        up = 1'b1; cmp_value = '0; clr_ovf = 1'b0;
        #12;
        total++;
        if ({count_w, tc_w, match_w, ovf_w} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {count_w, tc_w, match_w, ovf_w});
        end
        tick_clk();
        rst_n = 1'b1;
        tick_clk();
        total++;
        if (match_w !== 1'b1) begin
            bad++;
            $display("FAIL reset_match got=%b want=1", match_w);
        end
    endtask

    task automatic test_count_up();
        cmp_value = 8'hAA;
        ena = 1'b1; up = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick_clk();
            total++;
            if (count_w !== 8'(i) || tc_w !== 1'b0) begin
                bad++;
                $display("FAIL count_up[%0d] got=%h/%b want=%h/0",
                         i, count_w, tc_w, 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_c [4];
        logic       exp_t [4];
        logic       exp_o [4];
        exp_c = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b1};
        load_value = 8'hFE; load = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            load = 1'b0;
            total++;
            if (count_w !== exp_c[i] || tc_w !== exp_t[i] ||
                ovf_w !== exp_o[i]) begin
                bad++;
                $display("FAIL wrap[%0d] got=%h/%b/%b want=%h/%b/%b", i,
                         count_w, tc_w, ovf_w, exp_c[i], exp_t[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_c [4];
        logic       exp_t [4];
        logic       exp_o [4];
        exp_c = '{8'h01, 8'h00, 8'h00, 8'h00};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_o = '{1'b0, 1'b0, 1'b1, 1'b1};
        load_value = 8'h01; load = 1'b1; up = 1'b0; clr_ovf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick_clk();
            load = 1'b0; clr_ovf = 1'b0;
            total++;
            if (count_s !== exp_c[i] || tc_s !== exp_t[i] ||
                ovf_s !== exp_o[i]) begin
                bad++;
                $display("FAIL sat[%0d] got=%h/%b/%b want=%h/%b/%b", i,
                         count_s, tc_s, ovf_s, exp_c[i], exp_t[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [7:0] exp_c [14];
        logic       en_v  [14];
        exp_c = '{8'h0, 8'h0, 8'h0, 8'h1, 8'h1, 8'h1, 8'h1, 8'h2,
                  8'h2, 8'h2, 8'h2, 8'h2, 8'h2, 8'h3};
        en_v  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        load_value = 8'h00; load = 1'b1; up = 1'b1; ena = 1'b1;
        tick_clk();
        load = 1'b0;
        for (int i = 0; i < 14; i++) begin
            ena = en_v[i];
            tick_clk();
            total++;
            if (count_p !== exp_c[i]) begin
                bad++;
                $display("FAIL prescale[%0d] got=%h want=%h",
                         i, count_p, exp_c[i]);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_match();
        cmp_value = 8'h05; up = 1'b1; ena = 1'b1;
        load_value = 8'h00; load = 1'b1;
        tick_clk();
        load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick_clk();
            total++;
            if (match_w !== (i == 5)) begin
                bad++;
                $display("FAIL match_up[%0d] got=%b want=%b",
                         i, match_w, (i == 5));
            end
        end
        load_value = 8'h05; load = 1'b1;
        tick_clk();
        load = 1'b0; ena = 1'b0;
        total++;
        if (match_w !== 1'b1 || count_w !== 8'h05) begin
            bad++;
            $display("FAIL match_load got=%b/%h want=1/05", match_w, count_w);
        end
        ena = 1'b1;
    endtask

    task automatic test_load_priority();
        load_value = 8'h10; load = 1'b1; up = 1'b1; ena = 1'b1;
        tick_clk();
        load = 1'b0;
        total++;
        if (count_w !== 8'h10) begin
            bad++;
            $display("FAIL load_prio got=%h want=10", count_w);
        end
        tick_clk();
        total++;
        if (count_w !== 8'h11) begin
            bad++;
            $display("FAIL load_then_step got=%h want=11", count_w);
        end
    endtask

    task automatic test_ovf_clr();
        load_value = 8'hFF; load = 1'b1; clr_ovf = 1'b1; up = 1'b1;
        tick_clk();
        load = 1'b0;
        total++;
        if (ovf_w !== 1'b0) begin
            bad++;
            $display("FAIL ovf_cleared got=%b want=0", ovf_w);
        end
        tick_clk();
        total++;
        if (ovf_w !== 1'b1 || tc_w !== 1'b1 || count_w !== 8'h00) begin
            bad++;
            $display("FAIL ovf_set_wins got=%b/%b/%h want=1/1/00",
                     ovf_w, tc_w, count_w);
        end
        tick_clk();
        clr_ovf = 1'b0;
        total++;
        if (ovf_w !== 1'b0 || count_w !== 8'h01) begin
            bad++;
            $display("FAIL ovf_clr got=%b/%h want=0/01", ovf_w, count_w);
        end
    endtask

    task automatic test_mid_reset();
        cmp_value = 8'h03;
        tick_clk();
        tick_clk();
        total++;
        if (count_w !== 8'h03 || match_w !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%h/%b want=03/1", count_w, match_w);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({count_w, tc_w, match_w, ovf_w} !== 11'h0 ||
            count_s !== 8'h00 || count_p !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset got=%h/%h/%h want=0",
                     {count_w, tc_w, match_w, ovf_w}, count_s, count_p);
        end
        tick_clk();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_prescale();
        test_match();
        test_load_priority();
        test_ovf_clr();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
